mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single RAM port between an icache read port and a dcache
// read/write port; dcache bursts hold the grant, and a fairness bit lets the icache go next.
module mem_arbiter #(
  parameter int unsigned BURST_WORDS = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          iwait,
  output logic [AW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [AW-1:0] dstore,
  output logic          dwait,
  output logic [AW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [AW-1:0] ramstore,
  input  logic [AW-1:0] ramload,
  input  logic          ramready,
  output logic [1:0]    grant
);

  localparam int unsigned WW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          fair_q, fair_d;
  logic          d_req;

  assign d_req = dREN | dWEN;

  // State, word counter and fairness bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      fair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fair_q  <= fair_d;
    end
  end

  // Next-state logic: one-cycle arbitration from IDLE, bursts are not preempted.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fair_d  = fair_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(fair_q && iREN)) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        if (ramready || !iREN) begin
          state_d = IDLE;
          fair_d  = 1'b0;
        end
      end
      DGNT: begin
        if (!d_req || (ramready && (wcnt_q == WW'(BURST_WORDS - 1)))) begin
          state_d = IDLE;
          wcnt_d  = '0;
          fair_d  = iREN;
        end else if (ramready) begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
        fair_d  = 1'b0;
      end
    endcase
  end

  // RAM strobes and wait signals follow the current grant with no added delay.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = daddr;
    ramstore = dstore;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~ramready;
      end
      DGNT: begin
        ramWEN = dWEN;
        ramREN = dREN & ~dWEN;
        dwait  = ~ramready;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign grant = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN, ramready;
  logic [AW-1:0] iaddr, daddr, dstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [AW-1:0] iload, dload, ramaddr, ramstore;
  logic [1:0]    grant;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns the RAM, words finished in the burst, fairness.
  int owner = 0;
  int words = 0;
  bit fair  = 1'b0;

  mem_arbiter #(.BURST_WORDS(BW), .AW(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .grant(grant)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0t got=0x%0h want=0x%0h", tag, $time, obs, exp);
  endtask

  // One cycle: drive at negedge, check outputs mid-cycle, advance model at posedge.
  task automatic step(input bit rst_n, input bit ir, input logic [AW-1:0] ia,
                      input bit dr, input bit dw, input logic [AW-1:0] da,
                      input logic [AW-1:0] ds, input bit rdy, input logic [AW-1:0] rl);
    @(negedge CLK);
    nRST = rst_n; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ramready = rdy; ramload = rl;
    if (!rst_n) begin
      owner = 0; words = 0; fair = 1'b0;
    end
    #1;
    chk("grant", 64'(grant), 64'(owner));
    chk("iload", 64'(iload), 64'(rl));
    chk("dload", 64'(dload), 64'(rl));
    if (owner == 1) begin
      chk("ramREN", 64'(ramREN), 64'(ir));
      chk("ramWEN", 64'(ramWEN), 64'(0));
      chk("ramaddr", 64'(ramaddr), 64'(ia));
      chk("iwait", 64'(iwait), 64'(!rdy));
      chk("dwait", 64'(dwait), 64'(1));
    end else if (owner == 2) begin
      chk("ramREN", 64'(ramREN), 64'(dr && !dw));
      chk("ramWEN", 64'(ramWEN), 64'(dw));
      chk("ramaddr", 64'(ramaddr), 64'(da));
      chk("ramstore", 64'(ramstore), 64'(ds));
      chk("iwait", 64'(iwait), 64'(1));
      chk("dwait", 64'(dwait), 64'(!rdy));
    end else begin
      chk("ramREN", 64'(ramREN), 64'(0));
      chk("ramWEN", 64'(ramWEN), 64'(0));
      chk("iwait", 64'(iwait), 64'(1));
      chk("dwait", 64'(dwait), 64'(1));
    end
    @(posedge CLK);
    if (rst_n) begin
      if (owner == 0) begin
        if ((dr || dw) && !(fair && ir)) owner = 2;
        else if (ir) owner = 1;
      end else if (owner == 1) begin
        if (rdy || !ir) begin
          owner = 0; fair = 1'b0;
        end
      end else begin
        if (rdy) words++;
        if (!(dr || dw) || words == BW) begin
          owner = 0; words = 0; fair = ir;
        end
      end
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    #2;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_ramWEN", 64'(ramWEN), 64'(0));
    chk("rst_iwait", 64'(iwait), 64'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Icache single read, ready on second grant cycle.
    step(1, 1, 32'h100, 0, 0, 0, 0, 0, 32'h11);
    step(1, 1, 32'h100, 0, 0, 0, 0, 0, 32'h12);
    step(1, 1, 32'h100, 0, 0, 0, 0, 1, 32'h13);
    chk("i_back_idle_pre", 64'(owner), 64'(0));
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Dcache burst with icache waiting, then fairness forces IGNT.
    step(1, 1, 32'h300, 1, 0, 32'h200, 0, 0, 0);
    step(1, 1, 32'h300, 1, 0, 32'h200, 0, 1, 32'hA0);
    step(1, 1, 32'h300, 1, 0, 32'h204, 0, 1, 32'hA4);
    chk("fair_set", 64'(fair), 64'(1));
    step(1, 1, 32'h300, 1, 0, 32'h208, 0, 0, 0);
    chk("fair_ignt", 64'(owner), 64'(1));
    step(1, 1, 32'h300, 1, 0, 32'h208, 0, 1, 32'h33);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests with fair=0: dcache first.
    step(1, 1, 32'h400, 1, 0, 32'h500, 0, 0, 0);
    chk("d_first", 64'(owner), 64'(2));
    step(1, 1, 32'h400, 1, 0, 32'h500, 0, 1, 1);
    step(1, 1, 32'h400, 1, 0, 32'h504, 0, 1, 2);
    step(1, 1, 32'h400, 0, 0, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write wins over read; then reset mid-burst after word 0.
    step(1, 0, 0, 1, 1, 32'h600, 32'hDEADBEEF, 0, 0);
    step(1, 0, 0, 1, 1, 32'h600, 32'hDEADBEEF, 1, 0);
    step(0, 0, 0, 1, 1, 32'h604, 32'hDEADBEEF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Short write burst: must take two ready words, proving counter cleared.
    step(1, 0, 0, 0, 1, 32'h700, 32'h1, 0, 0);
    step(1, 0, 0, 0, 1, 32'h700, 32'h1, 1, 0);
    step(1, 0, 0, 0, 1, 32'h704, 32'h2, 1, 0);
    chk("burst_done", 64'(owner), 64'(0));

    // ramready in IDLE must be ignored.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 32'(i));
    step(1, 0, 0, 1, 0, 32'h800, 0, 0, 0);
    step(1, 0, 0, 1, 0, 32'h800, 0, 1, 0);
    chk("idle_rdy_cnt", 64'(owner), 64'(2));
    step(1, 0, 0, 1, 0, 32'h804, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 2) != 0), $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
           $urandom, $urandom,
           ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
